// File: rtl/conv_feeder_pkg.sv
// Shared types and default geometry for the convolution feeder.
// State encoding, default parameters and a counter-width helper.
package conv_feeder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DefaultTaps   = 9;
    localparam int unsigned DefaultStride = 1;
    localparam int unsigned DefaultNumOut = 16;
    localparam int unsigned DefaultAddrW  = 12;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Tap/output counters and SRAM read-address generation for the feeder.
// The input base address accumulates STRIDE per output, so no multiplier is needed.
module feeder_addr_gen
    import conv_feeder_pkg::*;
#(
    parameter int unsigned TAPS    = DefaultTaps,
    parameter int unsigned STRIDE  = DefaultStride,
    parameter int unsigned NUM_OUT = DefaultNumOut,
    parameter int unsigned ADDR_W  = DefaultAddrW,
    localparam int unsigned OutW   = cnt_width(NUM_OUT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [OutW-1:0]   out_idx,
    output logic              first_tap,
    output logic              last_tap,
    output logic              last_out
);

    localparam int unsigned TapW = cnt_width(TAPS);
    localparam logic [TapW-1:0]   TapLast = TapW'(TAPS - 1);
    localparam logic [OutW-1:0]   OutLast = OutW'(NUM_OUT - 1);
    localparam logic [ADDR_W-1:0] StrideA = ADDR_W'(STRIDE);

    logic [TapW-1:0]   tap_q, tap_d;
    logic [OutW-1:0]   out_q, out_d;
    logic [ADDR_W-1:0] base_q, base_d;

    assign first_tap = (tap_q == '0);
    assign last_tap  = (tap_q == TapLast);
    assign last_out  = (out_q == OutLast);

    always_comb begin
        tap_d  = tap_q;
        out_d  = out_q;
        base_d = base_q;
        if (step) begin
            if (last_tap) begin
                tap_d = '0;
                // Counters return to zero after the final tap so the next job starts clean.
                if (last_out) begin
                    out_d  = '0;
                    base_d = '0;
                end else begin
                    out_d  = out_q + 1'b1;
                    base_d = base_q + StrideA;
                end
            end else begin
                tap_d = tap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tap_q  <= '0;
            out_q  <= '0;
            base_q <= '0;
        end else begin
            tap_q  <= tap_d;
            out_q  <= out_d;
            base_q <= base_d;
        end
    end

    assign in_addr = base_q + ADDR_W'(tap_q);
    assign wt_addr = ADDR_W'(tap_q);
    assign out_idx = out_q;

endmodule

// File: rtl/conv_feeder.sv
// Convolution feeder: streams tap operand pairs into an external MAC and writes
// each finished accumulation back to the output SRAM.
module conv_feeder
    import conv_feeder_pkg::*;
#(
    parameter int unsigned TAPS    = DefaultTaps,
    parameter int unsigned STRIDE  = DefaultStride,
    parameter int unsigned NUM_OUT = DefaultNumOut,
    parameter int unsigned ADDR_W  = DefaultAddrW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [15:0]       in_data,
    output logic [ADDR_W-1:0] wt_addr,
    input  logic [15:0]       wt_data,
    output logic [15:0]       a,
    output logic [15:0]       b,
    output logic              clear,
    input  logic [15:0]       mac_msw,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       out_data,
    output logic              out_we
);

    localparam int unsigned OutW = cnt_width(NUM_OUT);

    state_e state_q, state_d;

    logic              issue;
    logic [ADDR_W-1:0] gen_in_addr, gen_wt_addr;
    logic [OutW-1:0]   gen_idx;
    logic              first_tap, last_tap, last_out;

    // Stage 1 aligns with SRAM data; stage 2 aligns with the registered MAC result.
    logic            v1_q, first1_q, last1_q, end1_q;
    logic [OutW-1:0] idx1_q;
    logic            we2_q, end2_q;
    logic [OutW-1:0] idx2_q;

    assign issue = (state_q == StRun);

    feeder_addr_gen #(
        .TAPS    (TAPS),
        .STRIDE  (STRIDE),
        .NUM_OUT (NUM_OUT),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .step      (issue),
        .in_addr   (gen_in_addr),
        .wt_addr   (gen_wt_addr),
        .out_idx   (gen_idx),
        .first_tap (first_tap),
        .last_tap  (last_tap),
        .last_out  (last_out)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_tap && last_out) state_d = StDrain;
            StDrain: if (end2_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            end1_q   <= 1'b0;
            idx1_q   <= '0;
            we2_q    <= 1'b0;
            end2_q   <= 1'b0;
            idx2_q   <= '0;
        end else begin
            state_q  <= state_d;
            v1_q     <= issue;
            first1_q <= first_tap;
            last1_q  <= last_tap;
            end1_q   <= last_tap && last_out;
            idx1_q   <= gen_idx;
            we2_q    <= v1_q && last1_q;
            end2_q   <= v1_q && last1_q && end1_q;
            idx2_q   <= idx1_q;
        end
    end

    // Control outputs are masked while reset is held so nothing leaks before the flush edge.
    assign busy     = !reset && ((state_q == StRun) || (state_q == StDrain));
    assign done     = !reset && (state_q == StDone);
    assign clear    = !reset && v1_q && first1_q;
    assign out_we   = !reset && we2_q;
    assign in_addr  = reset ? '0 : gen_in_addr;
    assign wt_addr  = reset ? '0 : gen_wt_addr;
    assign out_addr = reset ? '0 : ADDR_W'(idx2_q);

    assign a        = in_data;
    assign b        = wt_data;
    assign out_data = mac_msw;

endmodule

// File: tb/tb_conv_feeder.sv
// Self-checking bench: four feeder configurations with 1-cycle SRAMs and a registered MAC.
// Each job is traced per cycle, then compared against a table of hand-computed expectations.
module tb_conv_feeder;

    localparam int NI = 4;
    localparam int NJ = 7;
    localparam int MAXC = 32;
    localparam int P_TAPS   [NI] = '{3, 1, 3, 2};
    localparam int P_STRIDE [NI] = '{1, 1, 2, 5};
    localparam int P_NOUT   [NI] = '{2, 4, 2, 4};
    localparam int P_AW     [NI] = '{12, 12, 12, 4};

    localparam int SIG_BUSY = 0, SIG_DONE = 1, SIG_WE = 2, SIG_CLR = 3;
    localparam int SIG_OADDR = 4, SIG_ODATA = 5, SIG_IA = 6, SIG_NDONE = 7, SIG_NWE = 8;

    typedef struct {
        int          job;
        int          cyc;
        int          sig;
        logic [15:0] val;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_v [NI];
    logic        busy_v [NI], done_v [NI], we_v [NI], clr_v [NI];
    logic [11:0] ia_v [NI], oa_v [NI];
    logic [15:0] od_v [NI];
    logic [15:0] imem [NI][16];
    logic [15:0] wmem [NI][16];

    logic [15:0] tr [NJ][MAXC][7];
    int          n_done [NJ];
    int          n_we [NJ];
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl[$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int AW = P_AW[g];
        logic [AW-1:0]      ia, wa, oa;
        logic [15:0]        idat, wdat, aa, bb, od, msw;
        logic               clr;
        logic signed [31:0] acc, prod;

        conv_feeder #(
            .TAPS    (P_TAPS[g]),
            .STRIDE  (P_STRIDE[g]),
            .NUM_OUT (P_NOUT[g]),
            .ADDR_W  (AW)
        ) u_dut (
            .clock    (clk),
            .reset    (reset),
            .start    (start_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .in_addr  (ia),
            .in_data  (idat),
            .wt_addr  (wa),
            .wt_data  (wdat),
            .a        (aa),
            .b        (bb),
            .clear    (clr),
            .mac_msw  (msw),
            .out_addr (oa),
            .out_data (od),
            .out_we   (we_v[g])
        );

        assign prod = $signed(aa) * $signed(bb);
        assign msw  = acc[31:16];

        always @(posedge clk) begin
            idat <= imem[g][ia[3:0]];
            wdat <= wmem[g][wa[3:0]];
            acc  <= clr ? prod : acc + prod;
        end

        assign clr_v[g] = clr;
        assign ia_v[g]  = 12'(ia);
        assign oa_v[g]  = 12'(oa);
        assign od_v[g]  = od;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic void add(input int j, input int c, input int s, input logic [15:0] v,
                                input string n);
        tbl.push_back('{job: j, cyc: c, sig: s, val: v, name: n});
    endfunction

    // Cycle c starts at edge c-1; start/reset masks give the input level during each cycle.
    task automatic run_job(input int job, input int inst, input int ncyc,
                           input logic [31:0] smask, input logic [31:0] rmask);
        n_done[job] = 0;
        n_we[job]   = 0;
        for (int c = 0; c < MAXC; c++)
            for (int s = 0; s < 7; s++) tr[job][c][s] = 16'hxxxx;
        start_v[inst] = smask[0];
        reset         = rmask[0];
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            start_v[inst] = smask[c];
            reset         = rmask[c];
            #1;
            tr[job][c][SIG_BUSY]  = 16'(busy_v[inst]);
            tr[job][c][SIG_DONE]  = 16'(done_v[inst]);
            tr[job][c][SIG_WE]    = 16'(we_v[inst]);
            tr[job][c][SIG_CLR]   = 16'(clr_v[inst]);
            tr[job][c][SIG_OADDR] = 16'(oa_v[inst]);
            tr[job][c][SIG_ODATA] = od_v[inst];
            tr[job][c][SIG_IA]    = 16'(ia_v[inst]);
            if (done_v[inst]) n_done[job]++;
            if (we_v[inst]) n_we[job]++;
        end
        start_v[inst] = 1'b0;
        reset         = 1'b0;
    endtask

    initial begin
        int          seq_a [6];
        int          seq_c [6];
        int          seq_f [8];
        logic [15:0] act;

        reset = 1'b1;
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            imem[0][i] = 16'h4000;  wmem[0][i] = 16'h4000;
            imem[1][i] = 16'hC000;  wmem[1][i] = 16'h4000;
            imem[2][i] = 16'(i << 12); wmem[2][i] = 16'h1000;
            imem[3][i] = 16'h0000;  wmem[3][i] = 16'h0000;
        end

        // Reset state, both while reset is held and after release.
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst busy i%0d", i), 16'(busy_v[i]), 16'h0);
            check($sformatf("rst done i%0d", i), 16'(done_v[i]), 16'h0);
            check($sformatf("rst we i%0d", i), 16'(we_v[i]), 16'h0);
            check($sformatf("rst clr i%0d", i), 16'(clr_v[i]), 16'h0);
            check($sformatf("rst ia i%0d", i), 16'(ia_v[i]), 16'h0);
            check($sformatf("rst oa i%0d", i), 16'(oa_v[i]), 16'h0);
        end
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("idle busy", 16'(busy_v[0]), 16'h0);
        check("idle we", 16'(we_v[0]), 16'h0);

        // Job 0: TAPS=3 STRIDE=1 NUM_OUT=2, all 0x4000.
        add(0, 1, SIG_BUSY, 1, "A busy");      add(0, 2, SIG_CLR, 1, "A clr0");
        add(0, 3, SIG_CLR, 0, "A clr mid");    add(0, 5, SIG_CLR, 1, "A clr1");
        add(0, 4, SIG_WE, 0, "A we early");    add(0, 5, SIG_WE, 1, "A we0");
        add(0, 5, SIG_OADDR, 0, "A addr0");    add(0, 5, SIG_ODATA, 16'h3000, "A data0");
        add(0, 8, SIG_WE, 1, "A we1");         add(0, 8, SIG_OADDR, 1, "A addr1");
        add(0, 8, SIG_ODATA, 16'h3000, "A data1");
        add(0, 8, SIG_BUSY, 1, "A busy last"); add(0, 9, SIG_DONE, 1, "A done");
        add(0, 9, SIG_BUSY, 0, "A busy drop"); add(0, 10, SIG_BUSY, 0, "A idle");
        add(0, 0, SIG_NWE, 2, "A nwe");        add(0, 0, SIG_NDONE, 1, "A ndone");
        seq_a = '{0, 1, 2, 1, 2, 3};
        for (int c = 0; c < 6; c++) add(0, c + 1, SIG_IA, 16'(seq_a[c]), "A ia");

        // Job 1: TAPS=1, back-to-back writes.
        add(1, 2, SIG_WE, 0, "B we early");
        for (int c = 2; c <= 5; c++) add(1, c, SIG_CLR, 1, "B clr");
        add(1, 6, SIG_CLR, 0, "B clr end");
        for (int c = 3; c <= 6; c++) begin
            add(1, c, SIG_WE, 1, "B we");
            add(1, c, SIG_OADDR, 16'(c - 3), "B addr");
            add(1, c, SIG_ODATA, 16'hF000, "B data");
        end
        add(1, 7, SIG_DONE, 1, "B done");      add(1, 7, SIG_BUSY, 0, "B busy drop");
        add(1, 0, SIG_NWE, 4, "B nwe");

        // Job 2: STRIDE=2 address pattern and sums of products.
        seq_c = '{0, 1, 2, 2, 3, 4};
        for (int c = 0; c < 6; c++) add(2, c + 1, SIG_IA, 16'(seq_c[c]), "C ia");
        add(2, 5, SIG_ODATA, 16'h0300, "C data0"); add(2, 8, SIG_ODATA, 16'h0900, "C data1");
        add(2, 9, SIG_DONE, 1, "C done");

        // Job 3: start pulses while busy and in DONE are ignored.
        for (int c = 0; c < 6; c++) add(3, c + 1, SIG_IA, 16'(seq_a[c]), "D ia");
        add(3, 9, SIG_DONE, 1, "D done");      add(3, 0, SIG_NDONE, 1, "D ndone");
        add(3, 0, SIG_NWE, 2, "D nwe");        add(3, 11, SIG_BUSY, 0, "D no restart");
        add(3, 13, SIG_BUSY, 0, "D no queue");

        // Job 4: reset mid-RUN, then reset together with start.
        add(4, 2, SIG_BUSY, 1, "E busy");      add(4, 3, SIG_BUSY, 0, "E busy in rst");
        add(4, 4, SIG_BUSY, 0, "E busy after"); add(4, 4, SIG_WE, 0, "E we after");
        add(4, 7, SIG_BUSY, 0, "E rst wins");  add(4, 0, SIG_NDONE, 0, "E ndone");
        add(4, 0, SIG_NWE, 0, "E nwe");

        // Job 5: fresh job after the abort completes normally.
        add(5, 5, SIG_ODATA, 16'h3000, "E2 data0"); add(5, 8, SIG_WE, 1, "E2 we1");
        add(5, 9, SIG_DONE, 1, "E2 done");     add(5, 0, SIG_NWE, 2, "E2 nwe");

        // Job 6: ADDR_W=4 STRIDE=5 wrap.
        seq_f = '{0, 1, 5, 6, 10, 11, 15, 0};
        for (int c = 0; c < 8; c++) add(6, c + 1, SIG_IA, 16'(seq_f[c]), "F ia");
        add(6, 11, SIG_DONE, 1, "F done");     add(6, 0, SIG_NWE, 4, "F nwe");

        run_job(0, 0, 12, 32'h1, 32'h0);
        run_job(1, 1, 10, 32'h1, 32'h0);
        run_job(2, 2, 12, 32'h1, 32'h0);
        run_job(3, 0, 16, 32'h309, 32'h0);
        run_job(4, 0, 15, 32'h41, 32'h48);
        run_job(5, 0, 12, 32'h1, 32'h0);
        run_job(6, 3, 14, 32'h1, 32'h0);

        foreach (tbl[i]) begin
            if (tbl[i].sig == SIG_NDONE) act = 16'(n_done[tbl[i].job]);
            else if (tbl[i].sig == SIG_NWE) act = 16'(n_we[tbl[i].job]);
            else act = tr[tbl[i].job][tbl[i].cyc][tbl[i].sig];
            check($sformatf("%s (job %0d cycle %0d)", tbl[i].name, tbl[i].job, tbl[i].cyc),
                  act, tbl[i].val);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
